memory_request_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port memory controller (addr/wdata/read/write in, read_data/mem_ready out) between NUM_REQ requesters.
- Accepts one request at a time, drives the controller command until mem_ready, then returns read data or error to the winning requester.
- Sits between the requester-side fabric and the memory host controller.
- Includes a watchdog so a stalled controller cannot lock up the arbiter.

---
 rtl/memory_request_arbiter_if.sv | 36 +++
 rtl/memory_request_arbiter.sv | 130 +++++++++++++
 tb/tb_memory_request_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_request_arbiter_if.sv
// Requester-side and controller-side signal bundle for memory_request_arbiter.
// Handshake: a requester raises req_valid[i] and holds it with its command until
// req_grant[i] pulses. rsp_valid[i] later pulses once with rsp_rdata/rsp_error.
// Controller side: mem_read/mem_write stay high until mem_ready is seen.
interface memory_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_error;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         write_data;
  logic                      mem_read;
  logic                      mem_write;
  logic                      mem_ready;
  logic [DATA_W-1:0]         read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ready, read_data,
    output req_grant, rsp_valid, rsp_rdata, rsp_error,
           mem_addr, write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ready, read_data,
    input  req_grant, rsp_valid, rsp_rdata, rsp_error,
           mem_addr, write_data, mem_read, mem_write
  );
endinterface

// File: rtl/memory_request_arbiter.sv
// Round-robin arbiter sharing one single-port memory controller between
// NUM_REQ requesters, with a watchdog that aborts stalled controller commands.
module memory_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  memory_request_arbiter_if.slave bus,
  output logic                   busy,
  output logic [7:0]             timeout_count,
  output logic [1:0]             fsm_state
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_l;
  logic                we_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;
  logic [DATA_W-1:0]   rdata_r;
  logic                err_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic [NUM_REQ-1:0]  rsp_r;
  logic [7:0]          wd_cnt;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     idx;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Scan starts just after the last served requester, so it becomes lowest priority.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    idx       = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      id_l          <= '0;
      we_l          <= 1'b0;
      addr_l        <= '0;
      wdata_l       <= '0;
      rdata_r       <= '0;
      err_r         <= 1'b0;
      grant_r       <= '0;
      rsp_r         <= '0;
      wd_cnt        <= '0;
      timeout_count <= '0;
    end else begin
      grant_r <= '0;
      rsp_r   <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            id_l    <= win;
            we_l    <= sel_write;
            addr_l  <= sel_addr;
            wdata_l <= sel_wdata;
            grant_r <= NUM_REQ'(1) << win;
            wd_cnt  <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // A completion on the watchdog's last cycle still counts as success.
          if (bus.mem_ready) begin
            if (!we_l) rdata_r <= bus.read_data;
            err_r <= 1'b0;
            rsp_r <= NUM_REQ'(1) << id_l;
            state <= RESP;
          end else if (wd_cnt + 8'd1 == 8'(TIMEOUT)) begin
            wd_cnt  <= wd_cnt + 8'd1;
            rdata_r <= '0;
            err_r   <= 1'b1;
            rsp_r   <= NUM_REQ'(1) << id_l;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            state   <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RESP: begin
          rr_ptr <= id_l;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commands drop in the same cycle mem_ready is seen so the controller does not restart.
  assign bus.mem_read   = (state == ISSUE) && !we_l && !bus.mem_ready;
  assign bus.mem_write  = (state == ISSUE) &&  we_l && !bus.mem_ready;
  assign bus.mem_addr   = addr_l;
  assign bus.write_data = wdata_l;
  assign bus.req_grant  = grant_r;
  assign bus.rsp_valid  = rsp_r;
  assign bus.rsp_rdata  = rdata_r;
  assign bus.rsp_error  = err_r;
  assign busy           = (state != IDLE);
  assign fsm_state      = state;
endmodule

// File: tb/tb_memory_request_arbiter.sv
// Self-checking bench for memory_request_arbiter: randomized requesters and
// controller latency checked cycle by cycle against a transaction-level model.
module tb_memory_request_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] timeout_count;
  logic [1:0] fsm_state;

  memory_request_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_request_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .timeout_count(timeout_count), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- controller model ----------------
  int          ctl_lat   = 4;   // 0 means the controller never answers
  logic [31:0] ctl_rdata = '0;
  bit          spur      = 1'b0;
  int          ctl_cnt   = 0;

  initial begin
    bus.mem_ready = 1'b0;
    bus.read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (spur) begin
        bus.mem_ready = 1'b1;
      end else if (bus.mem_read || bus.mem_write) begin
        ctl_cnt++;
        if (ctl_lat != 0 && ctl_cnt == ctl_lat) begin
          bus.mem_ready = 1'b1;
          ctl_cnt = 0;
        end
      end else begin
        ctl_cnt = 0;
      end
      bus.read_data = bus.mem_ready ? ctl_rdata : $urandom;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int last);
    for (int j = 1; j <= NUM_REQ; j++)
      if (m[(last + j) % NUM_REQ]) return (last + j) % NUM_REQ;
    return -1;
  endfunction

  bit                        prev_idle = 1'b0;
  logic [NUM_REQ-1:0]        prev_valid, prev_write;
  logic [NUM_REQ*ADDR_W-1:0] prev_addr;
  logic [NUM_REQ*DATA_W-1:0] prev_wdata;
  bit                        inflight = 1'b0;
  int                        last_id = NUM_REQ - 1;
  int                        cur_id, cur_lat, k, n;
  bit                        cur_w;
  logic [31:0]               cur_addr, cur_wdata, cur_rd;
  logic [31:0]               hold_rdata = '0;
  bit                        hold_err = 1'b0;
  int                        exp_tc = 0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_grant, exp_rsp;
    bit in_issue, in_resp, ready_cyc;
    if (rst) begin
      inflight = 1'b0; last_id = NUM_REQ - 1; hold_rdata = '0; hold_err = 1'b0;
      exp_tc = 0; prev_idle = 1'b0;
    end else begin
      exp_grant = '0;
      if (prev_idle && prev_valid != '0) begin
        cur_id = rr_pick(prev_valid, last_id);
        exp_grant[cur_id] = 1'b1;
        cur_w     = prev_write[cur_id];
        cur_addr  = prev_addr[cur_id*ADDR_W +: ADDR_W];
        cur_wdata = prev_wdata[cur_id*DATA_W +: DATA_W];
        cur_lat   = ctl_lat;
        cur_rd    = ctl_rdata;
        n         = (cur_lat >= 1 && cur_lat <= TIMEOUT) ? cur_lat : TIMEOUT;
        k         = 0;
        inflight  = 1'b1;
      end
      check("grant", bus.req_grant, exp_grant);
      if (inflight) k++;
      in_issue  = inflight && k <= n;
      in_resp   = inflight && k == n + 1;
      ready_cyc = in_issue && k == cur_lat;
      check("mem_read", bus.mem_read, in_issue && !cur_w && !ready_cyc);
      check("mem_write", bus.mem_write, in_issue && cur_w && !ready_cyc);
      if (in_issue) begin
        check("mem_addr", bus.mem_addr, cur_addr);
        check("write_data", bus.write_data, cur_wdata);
      end
      check("busy", busy, inflight);
      exp_rsp = '0;
      if (in_resp) begin
        exp_rsp[cur_id] = 1'b1;
        if (cur_lat >= 1 && cur_lat <= TIMEOUT) begin
          if (!cur_w) hold_rdata = cur_rd;
          hold_err = 1'b0;
        end else begin
          hold_rdata = '0;
          hold_err   = 1'b1;
          if (exp_tc < 255) exp_tc++;
        end
      end
      check("rsp_valid", bus.rsp_valid, exp_rsp);
      check("rsp_rdata", bus.rsp_rdata, hold_rdata);
      check("rsp_error", bus.rsp_error, hold_err);
      check("timeout_count", timeout_count, exp_tc);
      prev_idle = !inflight;
      if (in_resp) begin
        inflight = 1'b0;
        last_id  = cur_id;
      end
    end
    prev_valid = bus.req_valid;
    prev_write = bus.req_write;
    prev_addr  = bus.req_addr;
    prev_wdata = bus.req_wdata;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_grant(output int id);
    int c = 0;
    id = -1;
    @(posedge clk); #1;
    while (bus.req_grant == '0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("grant_wait", |bus.req_grant, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) if (bus.req_grant[i]) id = i;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("idle_wait", busy, 1'b0);
  endtask

  task automatic set_req(input int id, input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.req_write[id] = w;
    bus.req_addr[id*ADDR_W +: ADDR_W] = a;
    bus.req_wdata[id*DATA_W +: DATA_W] = d;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic do_txn(input int id, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] rd);
    int g;
    ctl_lat = lat;
    ctl_rdata = rd;
    set_req(id, w, a, d);
    wait_grant(g);
    check("txn_grant_id", g, id);
    bus.req_valid[id] = 1'b0;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] exp_q[$];

  initial begin
    int g, lat;
    logic [NUM_REQ-1:0] mask;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b1;
    #1;
    check("rst_grant", bus.req_grant, '0);
    check("rst_rsp_valid", bus.rsp_valid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_tc", timeout_count, 8'd0);
    check("rst_mem_addr", bus.mem_addr, '0);
    check("rst_write_data", bus.write_data, '0);
    check("rst_rsp_rdata", bus.rsp_rdata, '0);
    check("rst_cmd", {bus.mem_read, bus.mem_write, bus.rsp_error}, 3'b000);
    apply_reset();

    // Fairness: every requester held high from reset.
    ctl_lat = 2;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int t = 0; t < 12; t++) begin
      exp_q.push_back(4'(t % NUM_REQ));
      wait_grant(g);
      check("fair_order", g, exp_q.pop_front());
    end
    bus.req_valid = '0;
    wait_idle();

    // Single read, then a write that must leave rsp_rdata alone.
    do_txn(2, 1'b0, 32'h5, 32'h0, 4, 32'h9ABCDEF5);
    check("read_rdata", bus.rsp_rdata, 32'h9ABCDEF5);
    check("read_err", bus.rsp_error, 1'b0);
    do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h11111111);
    check("write_keeps_rdata", bus.rsp_rdata, 32'h9ABCDEF5);

    // Race at the watchdog limit, and one cycle past it.
    do_txn(3, 1'b0, 32'h20, 32'h0, TIMEOUT, 32'hCAFEF00D);
    check("race_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    check("race_tc", timeout_count, 8'd0);
    do_txn(0, 1'b0, 32'h24, 32'h0, TIMEOUT + 1, 32'h12345678);
    check("late_err", bus.rsp_error, 1'b1);
    check("late_tc", timeout_count, 8'd1);

    // mem_ready while idle must be ignored.
    #1 spur = 1'b1;
    @(posedge clk); #2 spur = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("spur_state", fsm_state, 2'd0);

    // Randomized batches.
    for (int b = 0; b < 25; b++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      ctl_lat = $urandom_range(0, 18);
      ctl_rdata = $urandom;
      for (int i = 0; i < NUM_REQ; i++)
        if (mask[i]) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      while (bus.req_valid != '0) begin
        wait_grant(g);
        if (g >= 0) bus.req_valid[g] = 1'b0;
        else bus.req_valid = '0;
        wait_idle();
        ctl_lat = $urandom_range(0, 18);
        ctl_rdata = $urandom;
      end
    end

    // Repeated timeouts until the counter saturates.
    for (int t = 0; t < 300; t++)
      do_txn($urandom_range(0, NUM_REQ - 1), 1'b0, $urandom, 32'h0, 0, $urandom);
    check("tc_saturated", timeout_count, 8'd255);
    check("timeout_rdata", bus.rsp_rdata, 32'h0);

    // Reset during ISSUE.
    ctl_lat = 0;
    set_req(3, 1'b0, 32'h40, 32'h0);
    wait_grant(g);
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_read", bus.mem_read, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_read_drop", bus.mem_read, 1'b0);
    check("rst_busy_drop", busy, 1'b0);
    check("rst_no_rsp", bus.rsp_valid, '0);
    bus.req_valid = '1;
    ctl_lat = 3;
    ctl_rdata = 32'hA5A5A5A5;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    wait_grant(g);
    check("post_rst_first", g, 0);
    bus.req_valid = '0;
    wait_idle();
    check("post_rst_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
